// File: rtl/inst_fetch_sequencer_if.sv
// Bus bundle for inst_fetch_sequencer: the byte-wide instruction memory port
// and the {pc, inst} valid/ready stream toward IF/ID, plus the FIFO fill level.
// master = sequencer side; slave = memory + consumer side.
interface inst_fetch_sequencer_if #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] memAdr;
   logic [7:0]        memData;
   logic              instValid;
   logic [31:0]       inst;
   logic [31:0]       instPc;
   logic              instReady;
   logic [OCC_W-1:0]  occupancy;

   modport master (
      output memAdr,
      input  memData,
      output instValid,
      output inst,
      output instPc,
      input  instReady,
      output occupancy
   );

   modport slave (
      input  memAdr,
      output memData,
      input  instValid,
      input  inst,
      input  instPc,
      output instReady,
      input  occupancy
   );
endinterface

// File: rtl/inst_fetch_sequencer.sv
// inst_fetch_sequencer: reads four bytes per instruction from an
// asynchronous-read byte memory, assembles little-endian words and queues
// {pc, inst} pairs in a DEPTH-entry prefetch FIFO drained by IF/ID.
// A redirect flushes the FIFO and the partial word and restarts fetch.
// Optional feature macro IFETCH_BYPASS_EN: when the FIFO is empty the word
// being completed in B3 is presented directly on the output (3-cycle latency).
module inst_fetch_sequencer #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect,
   input  logic [31:0]           redirectPc,
   inst_fetch_sequencer_if.master bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   // byte counter doubles as the FSM state
   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } state_t;

   state_t           state_r;
   logic [31:0]      fetch_pc_r;
   logic [7:0]       b0_r;
   logic [7:0]       b1_r;
   logic [7:0]       b2_r;
   logic [31:0]      fifo_pc_r   [DEPTH];
   logic [31:0]      fifo_inst_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] count_r;

   logic [31:0]      word_s;
   logic             full_s;
   logic             empty_s;
   logic             fifo_pop_s;
   logic             bypass_s;
   logic             bypass_take_s;
   logic             advance_s;
   logic             push_s;
   logic             unused_pc_lsb_s;

   // the low PC bits of a redirect target are ignored by design
   assign unused_pc_lsb_s = ^redirectPc[1:0];

   // word assembly, FIFO status and the B3 push/advance decision
   always_comb begin
      word_s        = {bus.memData, b2_r, b1_r, b0_r};
      full_s        = (count_r == OCC_FULL);
      empty_s       = (count_r == {OCC_W{1'b0}});
      fifo_pop_s    = (!empty_s) && bus.instReady;
      bypass_s      = 1'b0;
      bypass_take_s = 1'b0;
      advance_s     = 1'b0;
      push_s        = 1'b0;
`ifdef IFETCH_BYPASS_EN
      if ((state_r == B3) && empty_s) begin
         bypass_s      = 1'b1;
         bypass_take_s = bus.instReady;
      end else begin
         bypass_s      = 1'b0;
         bypass_take_s = 1'b0;
      end
`endif
      // a pop in the same cycle frees the slot for the held word
      if ((state_r == B3) && (!full_s || fifo_pop_s)) begin
         advance_s = 1'b1;
         push_s    = !bypass_take_s;
      end else begin
         advance_s = 1'b0;
         push_s    = 1'b0;
      end
   end

   // memory address tracks the PC and byte counter; upper bits wrap away
   assign bus.memAdr    = {fetch_pc_r[ADDR_W-1:2], state_r};
   assign bus.instValid = (!empty_s) || bypass_s;
   assign bus.inst      = bypass_s ? word_s     : fifo_inst_r[rd_ptr_r];
   assign bus.instPc    = bypass_s ? fetch_pc_r : fifo_pc_r[rd_ptr_r];
   assign bus.occupancy = count_r;

   // fetch FSM, byte latches and prefetch FIFO; redirect overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= B0;
         fetch_pc_r <= 32'd0;
         b0_r       <= 8'd0;
         b1_r       <= 8'd0;
         b2_r       <= 8'd0;
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {OCC_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_r[i]   <= 32'd0;
            fifo_inst_r[i] <= 32'd0;
         end
      end else if (redirect) begin
         state_r    <= B0;
         fetch_pc_r <= {redirectPc[31:2], 2'b00};
         b0_r       <= 8'd0;
         b1_r       <= 8'd0;
         b2_r       <= 8'd0;
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {OCC_W{1'b0}};
      end else begin
         case (state_r)
            B0: begin
               b0_r    <= bus.memData;
               state_r <= B1;
            end
            B1: begin
               b1_r    <= bus.memData;
               state_r <= B2;
            end
            B2: begin
               b2_r    <= bus.memData;
               state_r <= B3;
            end
            B3: begin
               if (advance_s) begin
                  fetch_pc_r <= fetch_pc_r + 32'd4;
                  state_r    <= B0;
               end else begin
                  state_r    <= B3;
               end
            end
            default: begin
               state_r <= B0;
            end
         endcase

         if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= fetch_pc_r;
            fifo_inst_r[wr_ptr_r] <= word_s;
            wr_ptr_r              <= wr_ptr_r + PTR_ONE;
         end

         if (fifo_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end

         case ({push_s, fifo_pop_s})
            2'b10:   count_r <= count_r + OCC_ONE;
            2'b01:   count_r <= count_r - OCC_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Scoreboard bench for inst_fetch_sequencer: directed scenarios push the
// expected {pc, inst} stream into a queue; a negedge monitor pops and
// compares on every accepted handshake. Directed checks cover timing.
module tb_inst_fetch_sequencer;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4;
`ifdef IFETCH_BYPASS_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirectPc;

   inst_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   inst_fetch_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:4095];
   assign bus.memData = mem[bus.memAdr];

   int checks  = 0;
   int errors  = 0;
   int sb_hits = 0;
   logic [63:0] exp_q [$];

   function automatic logic [31:0] exp_word(input logic [31:0] pc);
      logic [11:0] a;
      a = pc[11:0];
      return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load_stream(input logic [31:0] start);
      logic [31:0] pc;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         pc = start + 32'(4 * i);
         exp_q.push_back({pc, exp_word(pc)});
      end
   endtask

   // monitor: compare each accepted instruction against the scoreboard
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && !redirect) begin
         checks++;
         if (int'(bus.occupancy) > DEPTH) begin
            errors++;
            $display("FAIL occupancy_bound: got %0d, limit %0d", bus.occupancy, DEPTH);
         end
         if (bus.instValid && bus.instReady) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got pc 0x%08h inst 0x%08h, expected none", bus.instPc, bus.inst);
            end else begin
               e = exp_q.pop_front();
               if ({bus.instPc, bus.inst} !== e) begin
                  errors++;
                  $display("FAIL sb_stream: got pc 0x%08h inst 0x%08h, expected pc 0x%08h inst 0x%08h",
                           bus.instPc, bus.inst, e[63:32], e[31:0]);
               end else begin
                  sb_hits++;
               end
            end
         end
      end
   end

   // issue a redirect in the current cycle (called at posedge+1); returns in cycle 0
   task automatic do_redirect(input logic [31:0] pc, input logic ready_after);
      redirect   = 1'b1;
      redirectPc = pc;
      @(posedge clk);
      #1;
      redirect      = 1'b0;
      bus.instReady = ready_after;
      load_stream({pc[31:2], 2'b00});
   endtask

   // common post-redirect checks: flushed at cycle 0, first word at LAT
   task automatic check_restart(input string tag, input logic [31:0] pc);
      for (int c = 0; c <= LAT; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (c == 0) begin
            check({tag, "_valid0"}, 32'(bus.instValid), 32'd0);
            check({tag, "_occ0"},   32'(bus.occupancy), 32'd0);
            check({tag, "_adr0"},   32'(bus.memAdr), pc);
         end
         if (c == LAT) begin
            check({tag, "_valid"},  32'(bus.instValid), 32'd1);
            check({tag, "_pc"},     bus.instPc, pc);
         end
      end
   endtask

   initial begin
      logic found;
      rst           = 1'b1;
      redirect      = 1'b0;
      redirectPc    = 32'd0;
      bus.instReady = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37 + 5) & 255);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_adr",   32'(bus.memAdr), 32'd0);
      check("rst_valid", 32'(bus.instValid), 32'd0);
      check("rst_occ",   32'(bus.occupancy), 32'd0);
      check("rst_inst",  bus.inst, 32'd0);
      check("rst_pc",    bus.instPc, 32'd0);

      // basic fetch
      @(posedge clk);
      #1;
      rst = 1'b0;
      load_stream(32'd0);
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         check("basic_adr", 32'(bus.memAdr), 32'(c));
         if (c == LAT - 1) check("basic_early", 32'(bus.instValid), 32'd0);
         if (c == LAT) begin
            check("basic_v0",   32'(bus.instValid), 32'd1);
            check("basic_i0",   bus.inst, 32'h44332211);
            check("basic_pc0",  bus.instPc, 32'd0);
         end
         if (c == LAT + 4) begin
            check("basic_v1",   32'(bus.instValid), 32'd1);
            check("basic_i1",   bus.inst, 32'h88776655);
            check("basic_pc1",  bus.instPc, 32'd4);
         end
      end

      // backpressure: fill the FIFO, then release
      @(posedge clk);
      #1;
      bus.instReady = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      load_stream(32'd0);
      for (int c = 0; c <= 29; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (c == 15) check("bp_occ15", 32'(bus.occupancy), 32'd3);
         if (c == 16) check("bp_occ16", 32'(bus.occupancy), 32'd4);
         if (c == 29) begin
            check("bp_occ29",  32'(bus.occupancy), 32'd4);
            check("bp_hold",   32'(bus.memAdr), 32'h13);
         end
      end
      @(posedge clk);
      #1;
      bus.instReady = 1'b1;
      for (int c = 30; c <= 34; c++) begin
         if (c > 30) @(posedge clk);
         @(negedge clk);
         check("bp_valid", 32'(bus.instValid), 32'd1);
         check("bp_pc",    bus.instPc, 32'(4 * (c - 30)));
         if (c == 30) check("bp_occ30", 32'(bus.occupancy), 32'd4);
         if (c == 31) check("bp_adr31", 32'(bus.memAdr), 32'h14);
      end

      // mid-word redirect in the byte-2 cycle
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(posedge clk);
         #1;
         if (bus.memAdr[1:0] == 2'd2) found = 1'b1;
      end
      check("find_b2", 32'(found), 32'd1);
      do_redirect(32'h107, 1'b1);
      check_restart("midword", 32'h104);

      // redirect coinciding with a pop
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(posedge clk);
         #1;
         if (bus.instValid) found = 1'b1;
      end
      check("find_pop", 32'(found), 32'd1);
      do_redirect(32'h200, 1'b1);
      check_restart("rdpop", 32'h200);

      // redirect while held in B3 with the FIFO full
      @(posedge clk);
      #1;
      bus.instReady = 1'b0;
      repeat (24) @(posedge clk);
      @(negedge clk);
      check("full_occ",  32'(bus.occupancy), 32'd4);
      check("full_b3",   32'(bus.memAdr[1:0]), 32'd3);
      @(posedge clk);
      #1;
      do_redirect(32'h300, 1'b1);
      check_restart("rdfull", 32'h300);

      // address wrap at the top of the 4 KB space
      @(posedge clk);
      #1;
      do_redirect(32'hFFC, 1'b1);
      for (int c = 0; c <= LAT + 4; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (c == 3) check("wrap_adr3", 32'(bus.memAdr), 32'hFFF);
         if (c == 4) check("wrap_adr4", 32'(bus.memAdr), 32'h000);
         if (c == LAT) begin
            check("wrap_pc0",   bus.instPc, 32'hFFC);
            check("wrap_i0",    bus.inst, exp_word(32'hFFC));
         end
         if (c == LAT + 4) begin
            check("wrap_pc1",   bus.instPc, 32'h1000);
            check("wrap_i1",    bus.inst, 32'h44332211);
         end
      end

      // reset in B2 with two entries queued
      @(posedge clk);
      #1;
      bus.instReady = 1'b0;
      do_redirect(32'h40, 1'b0);
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
      end
      check("mrst_occ", 32'(bus.occupancy), 32'd2);
      check("mrst_adr", 32'(bus.memAdr), 32'h4A);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mrst_adr0",   32'(bus.memAdr), 32'd0);
      check("mrst_valid0", 32'(bus.instValid), 32'd0);
      check("mrst_occ0",   32'(bus.occupancy), 32'd0);
      check("mrst_inst0",  bus.inst, 32'd0);
      check("mrst_pc0",    bus.instPc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.instReady = 1'b1;
      load_stream(32'd0);
      for (int c = 0; c <= LAT; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (c == LAT - 1) check("mrst_early", 32'(bus.instValid), 32'd0);
         if (c == LAT) begin
            check("mrst_valid", 32'(bus.instValid), 32'd1);
            check("mrst_pc",    bus.instPc, 32'd0);
            check("mrst_inst",  bus.inst, 32'h44332211);
         end
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sb_hits_min", 32'(sb_hits >= 12), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
